// File: rtl/onehot_sel_enc.sv
// onehot_sel_enc: registered one-hot to 2-bit select encoder behind a 2-entry valid/ready output buffer.
// Define ONEHOT_SEL_ENC_PRIO_EN to accept multi-hot codes, resolved by lowest set bit.
module onehot_sel_enc #(
  parameter int W_ERRCNT = 8
) (
  input  logic                ck,
  input  logic                res,
  input  logic [3:0]          zi,
  input  logic                zi_vld,
  output logic                zi_rdy,
  output logic [1:0]          sel,
  output logic                sel_vld,
  input  logic                sel_rdy,
  output logic                err,
  output logic [W_ERRCNT-1:0] err_cnt,
  input  logic                err_clr
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t r_state, w_next;
  logic [1:0] r_head, r_tail, w_code;
  logic [W_ERRCNT-1:0] r_cnt;
  logic w_valid, w_acc, w_push, w_pop, w_bad, r_rdy, r_err;
`ifdef ONEHOT_SEL_ENC_PRIO_EN
  assign w_valid = |zi;
  assign w_code  = zi[0] ? 2'd0 : zi[1] ? 2'd1 : zi[2] ? 2'd2 : 2'd3;
`else
  assign w_valid = (zi != 4'd0) && ((zi & (zi - 4'd1)) == 4'd0);
  assign w_code  = {zi[3] | zi[2], zi[3] | zi[1]};
`endif
  assign w_acc  = zi_vld & r_rdy;
  assign w_push = w_acc & w_valid;
  assign w_bad  = w_acc & ~w_valid;
  assign w_pop  = sel_vld & sel_rdy;
  // FULL never sees a push because zi_rdy is already low there
  always_comb begin
    w_next = (r_state == EMPTY) ? (w_push ? ONE : EMPTY) :
             (r_state == ONE)   ? ((w_push & ~w_pop) ? FULL : (~w_push & w_pop) ? EMPTY : ONE) :
             (w_pop ? ONE : FULL);
  end
  always_ff @(posedge ck or posedge res) begin
    if (res) begin
      r_state <= EMPTY;
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_rdy   <= (w_next != FULL);
      r_err   <= w_bad;
      r_cnt   <= err_clr ? '0 : (w_bad & ~&r_cnt) ? r_cnt + W_ERRCNT'(1) : r_cnt;
    end
  end
  // head is left untouched on the final pop so sel keeps the last value
  always_ff @(posedge ck or posedge res) begin
    if (res) begin
      r_head <= 2'd0;
      r_tail <= 2'd0;
    end else begin
      if ((r_state == EMPTY && w_push) || (r_state == ONE && w_push && w_pop))
        r_head <= w_code;
      else if (r_state == FULL && w_pop)
        r_head <= r_tail;
      if (r_state == ONE && w_push && !w_pop)
        r_tail <= w_code;
    end
  end
  assign zi_rdy  = r_rdy;
  assign sel     = r_head;
  assign sel_vld = (r_state != EMPTY);
  assign err     = r_err;
  assign err_cnt = r_cnt;
endmodule

// File: tb/tb_onehot_sel_enc.sv
// tb_onehot_sel_enc: directed vector table, reset/backpressure sequences and a scoreboarded random stream.
module tb_onehot_sel_enc;
  localparam int W = 2;
  logic ck = 1'b0, res = 1'b1;
  logic [3:0] zi = 4'd0;
  logic zi_vld = 1'b0, sel_rdy = 1'b0, err_clr = 1'b0;
  logic zi_rdy, sel_vld, err;
  logic [1:0] sel;
  logic [W-1:0] err_cnt;
  int total = 0, bad = 0;

  onehot_sel_enc #(.W_ERRCNT(W)) dut (
    .ck(ck), .res(res), .zi(zi), .zi_vld(zi_vld), .zi_rdy(zi_rdy),
    .sel(sel), .sel_vld(sel_vld), .sel_rdy(sel_rdy),
    .err(err), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic [3:0] zi;
    logic vld, rdy, clr;
    logic [1:0] sel;
    logic sv, zr, err;
    logic [1:0] cnt;
  } vec_t;

  vec_t tv [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic drive(input logic [3:0] z, input logic v, input logic r, input logic c);
    zi = z; zi_vld = v; sel_rdy = r; err_clr = c;
  endtask

  function automatic logic [2:0] model(input logic [3:0] z);
`ifdef ONEHOT_SEL_ENC_PRIO_EN
    if (z == 4'd0) return 3'b000;
    if (z[0]) return 3'b100;
    if (z[1]) return 3'b101;
    if (z[2]) return 3'b110;
    return 3'b111;
`else
    case (z)
      4'b0001: return 3'b100;
      4'b0010: return 3'b101;
      4'b0100: return 3'b110;
      4'b1000: return 3'b111;
      default: return 3'b000;
    endcase
`endif
  endfunction

  logic [1:0] q[$];
  logic [2:0] m;
  logic acc, pop, exp_err;

  initial begin
    tv = '{
      '{4'b0000,1'b0,1'b1,1'b0, 2'b00,1'b0,1'b1,1'b0,2'd0},
      '{4'b0001,1'b1,1'b1,1'b0, 2'b00,1'b1,1'b1,1'b0,2'd0},
      '{4'b0010,1'b1,1'b1,1'b0, 2'b01,1'b1,1'b1,1'b0,2'd0},
      '{4'b0100,1'b1,1'b1,1'b0, 2'b10,1'b1,1'b1,1'b0,2'd0},
      '{4'b1000,1'b1,1'b1,1'b0, 2'b11,1'b1,1'b1,1'b0,2'd0},
      '{4'b0000,1'b0,1'b1,1'b0, 2'b11,1'b0,1'b1,1'b0,2'd0},
      '{4'b0100,1'b1,1'b0,1'b0, 2'b10,1'b1,1'b1,1'b0,2'd0},
      '{4'b1000,1'b1,1'b0,1'b0, 2'b10,1'b1,1'b0,1'b0,2'd0},
      '{4'b0001,1'b1,1'b0,1'b0, 2'b10,1'b1,1'b0,1'b0,2'd0},
      '{4'b0000,1'b0,1'b1,1'b0, 2'b11,1'b1,1'b1,1'b0,2'd0},
      '{4'b0000,1'b0,1'b1,1'b0, 2'b11,1'b0,1'b1,1'b0,2'd0},
      '{4'b0000,1'b1,1'b1,1'b0, 2'b11,1'b0,1'b1,1'b1,2'd1},
      '{4'b0000,1'b1,1'b1,1'b0, 2'b11,1'b0,1'b1,1'b1,2'd2},
      '{4'b0000,1'b0,1'b1,1'b0, 2'b11,1'b0,1'b1,1'b0,2'd2},
      '{4'b0000,1'b1,1'b1,1'b0, 2'b11,1'b0,1'b1,1'b1,2'd3},
      '{4'b0000,1'b1,1'b1,1'b0, 2'b11,1'b0,1'b1,1'b1,2'd3},
      '{4'b0000,1'b1,1'b1,1'b1, 2'b11,1'b0,1'b1,1'b1,2'd0},
      '{4'b0000,1'b0,1'b1,1'b0, 2'b11,1'b0,1'b1,1'b0,2'd0},
      '{4'b1000,1'b1,1'b1,1'b0, 2'b11,1'b1,1'b1,1'b0,2'd0},
      '{4'b0000,1'b1,1'b1,1'b0, 2'b11,1'b0,1'b1,1'b1,2'd1},
      '{4'b0000,1'b0,1'b1,1'b1, 2'b11,1'b0,1'b1,1'b0,2'd0}
    };
    #12;
    chk("rst_sel", sel, 2'b00);
    chk("rst_sel_vld", sel_vld, 1'b0);
    chk("rst_zi_rdy", zi_rdy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_err_cnt", err_cnt, 2'd0);
    @(negedge ck);
    res = 1'b0;
    for (int i = 0; i < 21; i++) begin
      drive(tv[i].zi, tv[i].vld, tv[i].rdy, tv[i].clr);
      step();
      chk($sformatf("v%0d_sel", i), sel, tv[i].sel);
      chk($sformatf("v%0d_sel_vld", i), sel_vld, tv[i].sv);
      chk($sformatf("v%0d_zi_rdy", i), zi_rdy, tv[i].zr);
      chk($sformatf("v%0d_err", i), err, tv[i].err);
      chk($sformatf("v%0d_err_cnt", i), err_cnt, tv[i].cnt);
    end
    drive(4'b0011, 1'b1, 1'b0, 1'b0);
    step();
`ifdef ONEHOT_SEL_ENC_PRIO_EN
    chk("mh_sel", sel, 2'b00);
    chk("mh_sel_vld", sel_vld, 1'b1);
    chk("mh_err", err, 1'b0);
    chk("mh_err_cnt", err_cnt, 2'd0);
`else
    chk("mh_sel", sel, 2'b11);
    chk("mh_sel_vld", sel_vld, 1'b0);
    chk("mh_err", err, 1'b1);
    chk("mh_err_cnt", err_cnt, 2'd1);
`endif
    drive(4'b0000, 1'b0, 1'b1, 1'b1);
    step();
    chk("drain_sel_vld", sel_vld, 1'b0);
    chk("drain_err_cnt", err_cnt, 2'd0);
    drive(4'b0100, 1'b1, 1'b0, 1'b0);
    step();
    drive(4'b1000, 1'b1, 1'b0, 1'b0);
    step();
    chk("full_zi_rdy", zi_rdy, 1'b0);
    chk("full_sel", sel, 2'b10);
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
    #2 res = 1'b1;
    #1;
    chk("arst_sel", sel, 2'b00);
    chk("arst_sel_vld", sel_vld, 1'b0);
    chk("arst_zi_rdy", zi_rdy, 1'b0);
    @(negedge ck);
    res = 1'b0;
    step();
    chk("rel_zi_rdy", zi_rdy, 1'b1);
    drive(4'b0010, 1'b1, 1'b1, 1'b0);
    step();
    chk("rel_sel", sel, 2'b01);
    chk("rel_sel_vld", sel_vld, 1'b1);
    drive(4'b0000, 1'b0, 1'b1, 1'b0);
    step();
    chk("rel_empty", sel_vld, 1'b0);
    exp_err = 1'b0;
    for (int c = 0; c < 400; c++) begin
      int r;
      r = $urandom_range(0, 5);
      zi = (r < 4) ? 4'(1 << r) : (r == 4) ? 4'd0 : 4'($urandom);
      zi_vld = 1'($urandom);
      sel_rdy = 1'($urandom);
      chk("rnd_sel_vld", sel_vld, q.size() != 0);
      acc = zi_vld & zi_rdy;
      pop = sel_vld & sel_rdy;
      if (pop && q.size() > 0) chk("rnd_sel", sel, q.pop_front());
      m = model(zi);
      if (acc && m[2]) q.push_back(m[1:0]);
      exp_err = acc & ~m[2];
      step();
      chk("rnd_err", err, exp_err);
      chk("rnd_known", $isunknown({sel, sel_vld, err, zi_rdy}), 1'b0);
    end
    drive(4'b0000, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 4 && sel_vld; c++) begin
      if (q.size() > 0) chk("drn_sel", sel, q.pop_front());
      step();
    end
    chk("drn_q_empty", q.size(), 0);
    chk("drn_sel_vld", sel_vld, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
